gf8_mul_arbiter: RTL and testbench



---
 rtl/gf8_mul_arbiter.sv | 107 ++++++++++
 tb/tb_gf8_mul_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gf8_mul_arbiter.sv
// Round-robin arbiter sharing one GF(2^8) multiplier (poly 0x11B) between NREQ requesters.
// Products land in a single-entry, id-tagged response slot drained by valid/ready.
module gf8_mul_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   req_x,
    input  logic [8*NREQ-1:0]   req_y,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [7:0]          rsp_xy,
    output logic [IDW-1:0]      rsp_id
);

    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_xy_q, rsp_xy_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    logic            slot_free;
    logic            found;
    logic            gnt_vld;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  cand;
    logic [7:0]      op_x [NREQ];
    logic [7:0]      op_y [NREQ];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            // Multiply by x and fold the overflowing x^8 term back in as 0x1B.
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    assign slot_free = !rsp_valid_q || rsp_ready;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            op_x[i] = req_x[8*i +: 8];
            op_y[i] = req_y[8*i +: 8];
        end
    end

    // Search starts at ptr and wraps, so the last winner has lowest priority next time.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_vld = found && slot_free && !rst;
    end

    always_comb begin
        req_ready = '0;
        if (gnt_vld) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_xy_d    = rsp_xy_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        if (gnt_vld) begin
            rsp_valid_d = 1'b1;
            rsp_xy_d    = gmul(op_x[gnt_idx], op_y[gnt_idx]);
            rsp_id_d    = gnt_idx;
            ptr_d       = IDW'((32'(gnt_idx) + 1) % NREQ);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_xy_q    <= 8'h00;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_xy_q    <= rsp_xy_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_xy    = rsp_xy_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_gf8_mul_arbiter.sv
// Scoreboard bench for gf8_mul_arbiter: a queue-based reference model predicts grants and
// responses, a separate monitor checks each presented response against the queue head.
module tb_gf8_mul_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [8*N-1:0]   req_x;
    logic [8*N-1:0]   req_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_xy;
    logic [IDW-1:0]   rsp_id;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int id;
        int xy;
    } rsp_t;

    rsp_t         sb[$];
    int           m_ptr = 0;
    logic [N-1:0] m_gnt = '0;

    gf8_mul_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_xy    (rsp_xy),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Carry-less product then polynomial long division by 0x11B.
    function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Monitor: every presented response must match the scoreboard head.
    always @(negedge clk) begin
        check("rsp_valid", 32'(rsp_valid), 32'(sb.size() != 0));
        if (rsp_valid && sb.size() != 0) begin
            check("rsp_xy", 32'(rsp_xy), 32'(sb[0].xy));
            check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
            if (rsp_ready) void'(sb.pop_front());
        end
    end

    // Reference model: runs after the monitor so an empty queue means the slot is free.
    always @(negedge clk) begin
        int i;
        #1;
        m_gnt = '0;
        if (rst) begin
            sb.delete();
            m_ptr = 0;
        end else if (sb.size() == 0) begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (req_valid[i] && m_gnt == '0) begin
                    m_gnt[i] = 1'b1;
                    sb.push_back('{id: i, xy: int'(gf_ref(req_x[8*i +: 8], req_y[8*i +: 8]))});
                    m_ptr = (i + 1) % N;
                end
            end
        end
        check("req_ready", 32'(req_ready), 32'(m_gnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y);
        req_x[8*i +: 8] = x;
        req_y[8*i +: 8] = y;
    endtask

    logic [7:0] vx [5] = '{8'h57, 8'h02, 8'h00, 8'h01, 8'hFF};
    logic [7:0] vy [5] = '{8'h13, 8'h87, 8'hA5, 8'hA5, 8'hFF};
    logic [7:0] vp [5] = '{8'hFE, 8'h15, 8'h00, 8'hA5, 8'h13};

    initial begin
        int xfers;
        logic [7:0] bx, by;
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;

        // Reset with all requesters valid: nothing granted, slot cleared.
        #1;
        req_valid = '1;
        for (int i = 0; i < N; i++) set_op(i, 8'(17 * i + 3), 8'(29 * i + 5));
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_xy", 32'(rsp_xy), 32'h0);
        check("rst_id", 32'(rsp_id), 32'h0);
        check("rst_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All continuously valid: grants 0,1,2,3,0 and ids follow a cycle later.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rr_gnt", 32'(req_ready), 32'(1 << (c % 4)));
            if (c > 0) check("rr_id", 32'(rsp_id), 32'((c - 1) % 4));
        end
        tick();
        req_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rr_13", 32'(req_ready), (c % 2 == 0) ? 32'h2 : 32'h8);
        end

        // Single request from requester 2.
        tick();
        req_valid = 4'b0100;
        set_op(2, 8'h57, 8'h83);
        @(negedge clk);
        check("single_gnt", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("single_valid", 32'(rsp_valid), 32'h1);
        check("single_id", 32'(rsp_id), 32'h2);
        check("single_xy", 32'(rsp_xy), 32'hC1);

        // Known field products.
        for (int v = 0; v < 5; v++) begin
            tick();
            req_valid = 4'b0001;
            set_op(0, vx[v], vy[v]);
            @(negedge clk);
            tick();
            req_valid = '0;
            @(negedge clk);
            check("vector_xy", 32'(rsp_xy), 32'(vp[v]));
        end

        // Backpressure: slot holds 0xC1/id 0, requester 1 waits.
        tick();
        req_valid = 4'b0001;
        set_op(0, 8'h57, 8'h83);
        @(negedge clk);
        tick();
        bx = 8'h3C;
        by = 8'hD2;
        req_valid = 4'b0010;
        set_op(1, bx, by);
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready", 32'(req_ready), 32'h0);
            check("bp_xy", 32'(rsp_xy), 32'hC1);
            check("bp_id", 32'(rsp_id), 32'h0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_next_id", 32'(rsp_id), 32'h1);
        check("bp_next_xy", 32'(rsp_xy), 32'(gf_ref(bx, by)));

        // Reset with a pending response and ptr=2; requester 0 must then beat 3.
        tick();
        rst = 1'b1;
        req_valid = 4'b1001;
        set_op(0, 8'h11, 8'h22);
        set_op(3, 8'h33, 8'h44);
        @(negedge clk);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_gnt", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b1000;
        @(negedge clk);
        check("mid_rst_gnt3", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;

        // Random sweep: requesters hold until granted, random backpressure, rare resets.
        xfers = 0;
        for (int cyc = 0; cyc < 8000 && xfers < 1000; cyc++) begin
            tick();
            if (m_gnt != '0) xfers++;
            rst = ($urandom_range(0, 299) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (m_gnt[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_op(i, 8'($urandom), 8'($urandom));
                end
            end
        end
        check("sweep_count", 32'(xfers >= 1000), 32'h1);

        tick();
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
